// File: rtl/clint.sv
// Core-local interruptor: mtime / mtimecmp / msip on the data-memory slave bus,
// driving the CSR unit's machine timer and software interrupt levels.
module clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        timer_irpt,
  output logic        soft_irpt
);

  localparam int unsigned   CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  // Word offsets (byte offset >> 2) inside the 64 KiB region.
  localparam logic [13:0] W_MSIP   = 14'h0000;
  localparam logic [13:0] W_CMP_LO = 14'h1000;
  localparam logic [13:0] W_CMP_HI = 14'h1001;
  localparam logic [13:0] W_MT_LO  = 14'h2FFE;
  localparam logic [13:0] W_MT_HI  = 14'h2FFF;

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic          hit;
  logic [13:0]   word;
  logic          wr;
  logic [31:0]   rdata_nxt;

  logic [CW-1:0] cnt;
  logic          tick;
  logic [63:0]   mtime, mtime_nxt;
  logic [63:0]   mtimecmp, mtimecmp_nxt;
  logic          msip, msip_nxt;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          accept    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hit  = (mem_addr[31:16] == BASE_ADDR[31:16]);
  assign word = mem_addr[15:2];
  assign wr   = accept && hit && (mem_wstrb != 4'h0);
  assign tick = (cnt == CNT_MAX);

  // Read mux sees register values from before the edge that performs the access.
  always_comb begin
    rdata_nxt = '0;
    if (hit) begin
      case (word)
        W_MSIP:   rdata_nxt = {31'd0, msip};
        W_CMP_LO: rdata_nxt = mtimecmp[31:0];
        W_CMP_HI: rdata_nxt = mtimecmp[63:32];
        W_MT_LO:  rdata_nxt = mtime[31:0];
        W_MT_HI:  rdata_nxt = mtime[63:32];
        default:  rdata_nxt = '0;
      endcase
    end
  end

  // Bus bytes override the incremented value; the carry into the high half survives
  // whenever the high half itself is not being written.
  always_comb begin
    mtime_nxt = mtime + {63'd0, tick};
    if (wr && (word == W_MT_LO)) mtime_nxt[31:0]  = byte_merge(mtime_nxt[31:0], mem_wdata, mem_wstrb);
    if (wr && (word == W_MT_HI)) mtime_nxt[63:32] = byte_merge(mtime_nxt[63:32], mem_wdata, mem_wstrb);
  end

  always_comb begin
    mtimecmp_nxt = mtimecmp;
    msip_nxt     = msip;
    if (wr && (word == W_CMP_LO)) mtimecmp_nxt[31:0]  = byte_merge(mtimecmp[31:0], mem_wdata, mem_wstrb);
    if (wr && (word == W_CMP_HI)) mtimecmp_nxt[63:32] = byte_merge(mtimecmp[63:32], mem_wdata, mem_wstrb);
    if (wr && (word == W_MSIP) && mem_wstrb[0]) msip_nxt = mem_wdata[0];
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, which is what
  // gives read-before-write on the bus and the one-cycle lag on both interrupt levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      timer_irpt <= 1'b0;
      soft_irpt  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= tick ? '0 : cnt + 1'b1;
      mtime      <= mtime_nxt;
      mtimecmp   <= mtimecmp_nxt;
      msip       <= msip_nxt;
      mem_ready  <= accept;
      mem_rdata  <= accept ? rdata_nxt : '0;
      timer_irpt <= (mtime >= mtimecmp);
      soft_irpt  <= msip;
    end
  end

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (PRESCALE 1 and 4) share one bus and are compared
// every cycle against a register-level model, plus directed literal expectations.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, timer0, timer1, soft0, soft1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  clint #(.BASE_ADDR(32'h0200_0000), .PRESCALE(1)) dut0 (
    .rst(rst), .clk(clk), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(rdata0),
    .mem_ready(ready0), .timer_irpt(timer0), .soft_irpt(soft0)
  );

  clint #(.BASE_ADDR(32'h0200_0000), .PRESCALE(4)) dut1 (
    .rst(rst), .clk(clk), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(rdata1),
    .mem_ready(ready1), .timer_irpt(timer1), .soft_irpt(soft1)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mt [2];
  logic [63:0] m_cmp[2];
  logic        m_msip[2];
  logic        m_ready[2], m_timer[2], m_soft[2];
  logic [31:0] m_rdata[2];
  longint      m_n = 0;

  logic [63:0] o_mt, o_cmp, n_mt, n_cmp;
  logic        o_msip, n_msip, acc, hit;
  logic [15:0] off;
  logic [31:0] rd;

  function automatic longint pre(input int d);
    return (d == 0) ? 64'd1 : 64'd4;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[i*8 +: 8] = w[i*8 +: 8];
    return o;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_mt[d] = '0; m_cmp[d] = '1; m_msip[d] = 1'b0;
      m_ready[d] = 1'b0; m_timer[d] = 1'b0; m_soft[d] = 1'b0; m_rdata[d] = '0;
    end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          m_mt[d] = '0; m_cmp[d] = '1; m_msip[d] = 1'b0;
          m_ready[d] = 1'b0; m_timer[d] = 1'b0; m_soft[d] = 1'b0; m_rdata[d] = '0;
        end
        m_n = 0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          o_mt = m_mt[d]; o_cmp = m_cmp[d]; o_msip = m_msip[d];
          acc = mem_valid && !m_ready[d];
          hit = (mem_addr[31:16] == 16'h0200);
          off = {mem_addr[15:2], 2'b00};
          rd  = 32'd0;
          if (hit) begin
            case (off)
              16'h0000: rd = {31'd0, o_msip};
              16'h4000: rd = o_cmp[31:0];
              16'h4004: rd = o_cmp[63:32];
              16'hBFF8: rd = o_mt[31:0];
              16'hBFFC: rd = o_mt[63:32];
              default:  rd = 32'd0;
            endcase
          end
          n_mt   = o_mt + (((m_n % pre(d)) == pre(d) - 1) ? 64'd1 : 64'd0);
          n_cmp  = o_cmp;
          n_msip = o_msip;
          if (acc && hit && (mem_wstrb != 4'h0)) begin
            case (off)
              16'h0000: if (mem_wstrb[0]) n_msip = mem_wdata[0];
              16'h4000: n_cmp[31:0]  = bmerge(n_cmp[31:0], mem_wdata, mem_wstrb);
              16'h4004: n_cmp[63:32] = bmerge(n_cmp[63:32], mem_wdata, mem_wstrb);
              16'hBFF8: n_mt[31:0]   = bmerge(n_mt[31:0], mem_wdata, mem_wstrb);
              16'hBFFC: n_mt[63:32]  = bmerge(n_mt[63:32], mem_wdata, mem_wstrb);
              default: ;
            endcase
          end
          m_timer[d] = (o_mt >= o_cmp);
          m_soft[d]  = o_msip;
          m_ready[d] = acc;
          m_rdata[d] = acc ? rd : 32'd0;
          m_mt[d]    = n_mt;
          m_cmp[d]   = n_cmp;
          m_msip[d]  = n_msip;
        end
        m_n++;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial forever begin
    @(negedge clk);
    check("ready0", {63'd0, ready0}, {63'd0, m_ready[0]});
    check("rdata0", {32'd0, rdata0}, {32'd0, m_rdata[0]});
    check("timer0", {63'd0, timer0}, {63'd0, m_timer[0]});
    check("soft0",  {63'd0, soft0},  {63'd0, m_soft[0]});
    check("ready1", {63'd0, ready1}, {63'd0, m_ready[1]});
    check("rdata1", {32'd0, rdata1}, {32'd0, m_rdata[1]});
    check("timer1", {63'd0, timer1}, {63'd0, m_timer[1]});
    check("soft1",  {63'd0, soft1},  {63'd0, m_soft[1]});
  end

  // ---------------- bus driver ----------------
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] r0, output logic [31:0] r1, output int ac);
    bit got;
    got = 1'b0;
    r0 = '0; r1 = '0; ac = 0;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = st;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ready0) begin
        got = 1'b1;
        r0 = rdata0; r1 = rdata1; ac = cyc;
      end
    end
    if (!got) check("bus_timeout", 64'd0, 64'd1);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [31:0] r0, r1, r0b, r1b, wd, a;
    logic [3:0]  st;
    int          ac, ac2, cw, gap, sel;
    bit          seen;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_ready", {63'd0, ready0}, 64'd0);
    check("rst_rdata", {32'd0, rdata0}, 64'd0);
    check("rst_timer", {63'd0, timer0}, 64'd0);
    check("rst_soft",  {63'd0, soft1},  64'd0);

    idle_cycles(10);
    bus(32'h0200_BFF8, 32'd0, 4'h0, r0, r1, ac);
    check("mtime_lo_after_idle", {63'd0, (r0 >= 32'd10)}, 64'd1);
    check("mtime_lo_exact_10", {32'd0, r0}, 64'd10);
    bus(32'h0200_BFFC, 32'd0, 4'h0, r0, r1, ac);
    check("mtime_hi_zero", {32'd0, r0}, 64'd0);
    check("timer_low_initial", {63'd0, timer0}, 64'd0);

    // mtime := 0, mtimecmp := 20, then measure when timer_irpt rises.
    bus(32'h0200_BFF8, 32'd0, 4'hF, r0, r1, cw);
    bus(32'h0200_4004, 32'd0, 4'hF, r0, r1, ac);
    bus(32'h0200_4000, 32'd20, 4'hF, r0, r1, ac);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (timer0) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("timer_rise_seen", {63'd0, seen}, 64'd1);
    check("timer_rise_cycle", 64'(cyc - cw), 64'd21);
    bus(32'h0200_4004, 32'd1, 4'hF, r0, r1, ac);
    idle_cycles(1);
    check("timer_cleared", {63'd0, timer0}, 64'd0);

    // Software interrupt.
    bus(32'h0200_0000, 32'hFFFF_FFFF, 4'hF, r0, r1, ac);
    idle_cycles(1);
    check("soft_set", {63'd0, soft0}, 64'd1);
    bus(32'h0200_0000, 32'd0, 4'h0, r0, r1, ac);
    check("msip_read", {32'd0, r0}, 64'd1);
    bus(32'h0200_0000, 32'd0, 4'hF, r0, r1, ac);
    idle_cycles(1);
    check("soft_clear", {63'd0, soft1}, 64'd0);

    // Partial byte write to mtimecmp low.
    bus(32'h0200_4000, 32'hAABB_CCDD, 4'b0010, r0, r1, ac);
    bus(32'h0200_4000, 32'd0, 4'h0, r0, r1, ac);
    check("wstrb_byte1_p1", {32'd0, r0}, 64'h0000_CC14);
    check("wstrb_byte1_p4", {32'd0, r1}, 64'h0000_CC14);

    // PRESCALE=4 rate over 100 cycles.
    bus(32'h0200_BFF8, 32'd0, 4'h0, r0, r1, ac);
    while (cyc < ac + 99) begin @(posedge clk); #1; end
    bus(32'h0200_BFF8, 32'd0, 4'h0, r0b, r1b, ac2);
    check("p4_window", 64'(ac2 - ac), 64'd100);
    check("p4_delta", {32'd0, r1b - r1}, 64'd25);
    check("p1_delta", {32'd0, r0b - r0}, 64'd100);

    // Carry from low half into high half.
    bus(32'h0200_BFFC, 32'd0, 4'hF, r0, r1, ac);
    bus(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, r0, r1, cw);
    bus(32'h0200_BFFC, 32'd0, 4'h0, r0, r1, ac);
    check("carry_hi", {32'd0, r0}, 64'd1);
    bus(32'h0200_BFF8, 32'd0, 4'h0, r0, r1, ac);
    check("carry_lo", {32'd0, r0}, 64'(ac - cw - 2));

    // Unmapped offset and region miss.
    bus(32'h0200_1234, 32'd0, 4'h0, r0, r1, ac);
    check("unmapped_rdata", {r1, r0}, 64'd0);
    bus(32'h3000_0000, 32'd0, 4'h0, r0, r1, ac);
    check("miss_rdata", {r1, r0}, 64'd0);
    idle_cycles(1);
    check("ready_one_cycle", {63'd0, ready0}, 64'd0);

    // Reset while the response is on the bus.
    bus(32'h0200_4004, 32'd0, 4'h0, r0, r1, ac);
    rst = 1'b0;
    #1;
    check("rst_mid_resp_ready0", {63'd0, ready0}, 64'd0);
    check("rst_mid_resp_ready1", {63'd0, ready1}, 64'd0);
    check("rst_mid_resp_rdata", {32'd0, rdata0}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus(32'h0200_BFF8, 32'd0, 4'h0, r0, r1, ac);
    check("post_rst_mtime", {r1, r0}, 64'd0);
    bus(32'h0200_4004, 32'd0, 4'h0, r0, r1, ac);
    check("post_rst_cmp_hi", {32'd0, r0}, 64'hFFFF_FFFF);

    // Randomized traffic; the per-cycle comparison does the checking.
    for (int t = 0; t < 400; t++) begin
      sel = int'($urandom_range(0, 6));
      case (sel)
        0:       a = 32'h0200_0000;
        1:       a = 32'h0200_4000;
        2:       a = 32'h0200_4004;
        3:       a = 32'h0200_BFF8;
        4:       a = 32'h0200_BFFC;
        5:       a = {16'h0200, 14'($urandom), 2'b00};
        default: a = $urandom;
      endcase
      st = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      if ((sel == 2 || sel == 4) && ($urandom_range(0, 1) == 1)) wd = $urandom_range(0, 2);
      if (sel == 1 && ($urandom_range(0, 1) == 1)) wd = $urandom_range(0, 400);
      bus(a, wd, st, r0, r1, ac);
      gap = int'($urandom_range(0, 3));
      idle_cycles(gap);
    end

    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
